// File: rtl/mbs_fsk_pkg.sv
// mbs_fsk_pkg: state encoding, PN taps and tone constants shared by the mbs FSK transmitter and receiver.
package mbs_fsk_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACQUIRE = 2'd1, TRACK = 2'd2} fsk_state_t;
  localparam int PN_LEN      = 5;
  localparam int PN_TAP_HI   = 4;
  localparam int PN_TAP_LO   = 2;
  localparam int TONE0_EDGES = 8;
  localparam int TONE1_EDGES = 16;
  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic inc);
    return (inc && v != 8'hff) ? v + 8'd1 : v;
  endfunction
  function automatic logic pn_predict(input logic [PN_LEN-1:0] s);
    return s[PN_TAP_HI] ^ s[PN_TAP_LO];
  endfunction
endpackage

// File: rtl/mbs_fsk_slicer.sv
// mbs_fsk_slicer: pad synchroniser, rising-edge detect, symbol window timer and per-window edge counter.
module mbs_fsk_slicer
  import mbs_fsk_pkg::*;
#(
  parameter int SYM_CLKS = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic       i_active,
  input  logic       i_fsk_in,
  output logic       o_start,
  output logic       o_win_end,
  output logic       o_carrier_lost,
  output logic [7:0] o_edge_cnt
);
  localparam int TW = $clog2(SYM_CLKS);
  logic [2:0]    r_sync;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_edge_cnt;
  logic          w_rise, w_run;
  assign w_rise         = r_sync[1] & ~r_sync[2];
  assign w_run          = i_active & i_enable;
  assign o_start        = ~i_active & i_enable & w_rise;
  assign o_win_end      = w_run && r_timer == TW'(SYM_CLKS - 1);
  assign o_carrier_lost = o_win_end && r_edge_cnt == 8'd0;
  assign o_edge_cnt     = r_edge_cnt;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync     <= '0;
      r_timer    <= '0;
      r_edge_cnt <= '0;
    end else begin
      r_sync <= {r_sync[1:0], i_fsk_in};
      if (o_start) begin
        r_timer    <= TW'(1);
        r_edge_cnt <= 8'd1;
      end else if (!w_run) begin
        r_timer    <= '0;
        r_edge_cnt <= '0;
      end else begin
        r_timer    <= o_win_end ? '0 : r_timer + TW'(1);
        // a rise landing on the window end belongs to the next window
        r_edge_cnt <= o_win_end ? {7'd0, w_rise} : sat_inc8(r_edge_cnt, w_rise);
      end
    end
  end
endmodule

// File: rtl/mbs_fsk_rx.sv
// mbs_fsk_rx: FSK receiver; slices edge counts into bits and checks them against PN(x^5+x^3+1).
module mbs_fsk_rx
  import mbs_fsk_pkg::*;
#(
  parameter int SYM_CLKS    = 1024,
  parameter int EDGE_THRESH = 12,
  parameter int LOS_ERRS    = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_clear_err,
  input  logic        i_fsk_in,
  output logic        o_bit_valid,
  output logic        o_bit_data,
  output logic        o_locked,
  output logic        o_sync_err,
  output logic [7:0]  o_err_count,
  output logic [15:0] o_bit_count,
  output logic [1:0]  o_state
);
  fsk_state_t        r_state, w_state_nx;
  logic [PN_LEN-1:0] r_pn, w_pn_nx;
  logic [2:0]        r_fill, w_fill_nx;
  logic [7:0]        r_consec, w_consec_nx, r_err, w_edge_cnt;
  logic [15:0]       r_bit_cnt;
  logic              r_bit_valid, r_bit_data, r_sync_err;
  logic              w_active, w_start, w_win_end, w_carrier_lost, w_dec, w_bit, w_mis;
  assign w_active = r_state != IDLE;
  mbs_fsk_slicer #(.SYM_CLKS(SYM_CLKS)) u_slicer (
    .i_clk          (i_clk),
    .i_rst          (i_reset),
    .i_enable       (i_enable),
    .i_active       (w_active),
    .i_fsk_in       (i_fsk_in),
    .o_start        (w_start),
    .o_win_end      (w_win_end),
    .o_carrier_lost (w_carrier_lost),
    .o_edge_cnt     (w_edge_cnt)
  );
  assign w_dec   = w_win_end & ~w_carrier_lost;
  assign w_bit   = w_edge_cnt >= 8'(EDGE_THRESH);
  assign w_pn_nx = {r_pn[PN_LEN-2:0], w_bit};
  assign w_mis   = w_dec && r_state == TRACK && w_bit != pn_predict(r_pn);
  always_comb begin
    w_state_nx  = r_state;
    w_fill_nx   = r_fill;
    w_consec_nx = r_consec;
    if (!i_enable || w_carrier_lost) begin
      w_state_nx  = IDLE;
      w_fill_nx   = '0;
      w_consec_nx = '0;
    end else if (r_state == IDLE) begin
      w_state_nx = w_start ? ACQUIRE : IDLE;
    end else if (w_dec && r_state == ACQUIRE) begin
      w_fill_nx = (r_fill == 3'(PN_LEN)) ? r_fill : r_fill + 3'd1;
      // an all-zero register is the LFSR lock-up state, so keep filling
      if (w_fill_nx == 3'(PN_LEN) && w_pn_nx != '0) begin
        w_state_nx = TRACK;
        w_fill_nx  = '0;
      end
    end else if (w_dec && r_state == TRACK) begin
      w_consec_nx = w_mis ? r_consec + 8'd1 : 8'd0;
      if (w_consec_nx == 8'(LOS_ERRS)) begin
        w_state_nx  = ACQUIRE;
        w_fill_nx   = '0;
        w_consec_nx = '0;
      end
    end
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_pn        <= '0;
      r_fill      <= '0;
      r_consec    <= '0;
      r_err       <= '0;
      r_bit_cnt   <= '0;
      r_bit_valid <= 1'b0;
      r_bit_data  <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_fill      <= w_fill_nx;
      r_consec    <= w_consec_nx;
      r_bit_valid <= w_dec;
      r_sync_err  <= w_mis;
      r_err       <= i_clear_err ? 8'd0 : sat_inc8(r_err, w_mis);
      if (w_dec) begin
        r_bit_data <= w_bit;
        r_pn       <= w_pn_nx;
        r_bit_cnt  <= r_bit_cnt + 16'd1;
      end
    end
  end
  assign o_bit_valid = r_bit_valid;
  assign o_bit_data  = r_bit_data;
  assign o_locked    = r_state == TRACK;
  assign o_sync_err  = r_sync_err;
  assign o_err_count = r_err;
  assign o_bit_count = r_bit_cnt;
  assign o_state     = r_state;
endmodule

// File: tb/tb_mbs_fsk_rx.sv
// tb_mbs_fsk_rx: randomized-tone bench for mbs_fsk_rx checked against a bit-history reference model.
module tb_mbs_fsk_rx;
  localparam int SYM = 128, TH = 12, LOS = 4;
  logic clk = 0, rst = 1, en = 0, clr = 0, fsk = 0;
  logic bv, bd, lk, se;
  logic [7:0] ec;
  logic [15:0] bc;
  logic [1:0] st;
  mbs_fsk_rx #(.SYM_CLKS(SYM), .EDGE_THRESH(TH), .LOS_ERRS(LOS)) dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_clear_err(clr), .i_fsk_in(fsk),
    .o_bit_valid(bv), .o_bit_data(bd), .o_locked(lk), .o_sync_err(se),
    .o_err_count(ec), .o_bit_count(bc), .o_state(st)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic b; logic e; logic l; logic [1:0] st; logic [7:0] ec; logic [15:0] bc; int c;
  } obs_t;
  obs_t q_obs[$], q_exp[$];
  int n_chk = 0, n_pass = 0, n_fail = 0, n_stray = 0;
  int m_mode, m_fill, m_consec, m_err, m_cnt;
  bit m_hist[$];
  bit pend_clr = 0;
  bit pn[64];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_mode = 0; m_fill = 0; m_consec = 0; m_err = 0; m_cnt = 0;
    m_hist.delete();
    repeat (5) m_hist.push_back(1'b0);
  endtask
  task automatic model_bit(input bit b, input bit clr_it);
    int k;
    bit pred, mis, any;
    obs_t e;
    k = m_hist.size();
    pred = m_hist[k-5] ^ m_hist[k-3];
    mis = 0;
    m_hist.push_back(b);
    m_cnt = (m_cnt + 1) % 65536;
    if (m_mode == 2) begin
      mis = (b != pred);
      m_consec = mis ? m_consec + 1 : 0;
      if (mis && m_err < 255) m_err++;
      if (m_consec == LOS) begin m_mode = 1; m_fill = 0; m_consec = 0; end
    end else begin
      m_fill = (m_fill < 5) ? m_fill + 1 : 5;
      any = 0;
      for (int j = 0; j < 5; j++) any |= m_hist[k-j];
      if (m_fill == 5 && any) begin m_mode = 2; m_fill = 0; end
    end
    if (clr_it) m_err = 0;
    e = '{b, mis, m_mode == 2, 2'(m_mode), 8'(m_err), 16'(m_cnt), 2};
    q_exp.push_back(e);
  endtask
  task automatic cyc(input logic lvl, input int c, input logic cl);
    obs_t o;
    @(posedge clk); #1;
    if (bv) begin
      o = '{bd, se, lk, st, ec, bc, c};
      q_obs.push_back(o);
    end
    if (se && !bv) n_stray++;
    fsk = lvl;
    clr = cl;
  endtask
  task automatic send_part(input int n, input int len);
    logic lvl;
    int off;
    for (int c = 0; c < len; c++) begin
      lvl = 0;
      for (int i = 0; i < n; i++) begin
        off = i * SYM / n;
        if (c >= off && c < off + 3) lvl = 1;
      end
      cyc(lvl, c, pend_clr && c == 1);
    end
    pend_clr = 0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, -1, 1'b0);
  endtask
  task automatic tx(input int n, input bit clr_it);
    if (m_mode == 0) m_mode = 1;
    model_bit(n >= TH, clr_it);
    send_part(n, SYM);
    pend_clr = clr_it;
  endtask
  task automatic tx_bit(input bit b, input bit clr_it);
    tx(b ? $urandom_range(16, TH) : $urandom_range(TH - 1, 7), clr_it);
  endtask
  task automatic tx_anti(input bit clr_it);
    int k;
    k = m_hist.size();
    tx_bit(~(m_hist[k-5] ^ m_hist[k-3]), clr_it);
  endtask
  task automatic tx_zero();
    send_part(0, SYM);
    m_mode = 0; m_fill = 0; m_consec = 0;
    idle(3);
  endtask
  task automatic drain(input string tag);
    obs_t o, e;
    check({tag, "/strobes"}, q_obs.size(), q_exp.size());
    while (q_obs.size() > 0 && q_exp.size() > 0) begin
      o = q_obs.pop_front();
      e = q_exp.pop_front();
      check({tag, "/bit"}, o.b, e.b);
      check({tag, "/sync_err"}, o.e, e.e);
      check({tag, "/locked"}, o.l, e.l);
      check({tag, "/state"}, o.st, e.st);
      check({tag, "/err_count"}, o.ec, e.ec);
      check({tag, "/bit_count"}, o.bc, e.bc);
      check({tag, "/strobe_pos"}, o.c, e.c);
    end
    q_obs.delete();
    q_exp.delete();
  endtask
  initial begin
    int nerr;
    for (int i = 0; i < 4; i++) pn[i] = 0;
    pn[4] = 1;
    for (int i = 5; i < 64; i++) pn[i] = pn[i-5] ^ pn[i-3];
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bv, bd, lk, se, ec, bc, st}, '0);
    rst = 0; en = 1;
    // reset in the middle of a window of a 16-edge tone
    repeat (3) send_part(16, SYM);
    send_part(16, 500 - 3 * SYM);
    check("pre_reset_active", st != 2'd0, 1);
    #2 rst = 1;
    #1;
    check("async_reset_outputs", {bv, bd, lk, se, ec, bc}, '0);
    check("async_reset_state", st, 0);
    fsk = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    q_obs.delete();
    model_reset();
    idle(4);
    check("post_reset_state", st, 0);
    // threshold boundary: 11 edges then 12 edges
    tx(11, 0);
    tx(12, 0);
    tx_zero();
    check("thr_bit0", q_obs.size() > 0 ? q_obs[0].b : 1'bx, 0);
    check("thr_bit1", q_obs.size() > 1 ? q_obs[1].b : 1'bx, 1);
    drain("thr");
    check("thr_bit_count", bc, 2);
    check("thr_carrier_idle", st, 0);
    // clean PN stream
    for (int i = 0; i < 40; i++) tx_bit(pn[i], 0);
    tx_zero();
    check("pn_unlock4", q_obs.size() > 3 ? q_obs[3].l : 1'bx, 0);
    check("pn_lock5", q_obs.size() > 4 ? q_obs[4].l : 1'bx, 1);
    check("pn_state5", q_obs.size() > 4 ? q_obs[4].st : 2'bx, 2);
    drain("pn");
    check("pn_err_count", ec, 0);
    check("pn_stray_sync_err", n_stray, 0);
    // single channel error at symbol 20, then forced loss of sync and relock
    for (int i = 0; i < 40; i++) tx_bit(pn[i] ^ (i == 20), 0);
    for (int i = 0; i < 4; i++) tx_anti(0);
    for (int i = 44; i < 52; i++) tx_bit(pn[i], 0);
    tx_zero();
    nerr = 0;
    for (int i = 0; i < 40 && i < q_obs.size(); i++) nerr += int'(q_obs[i].e);
    check("se_count", nerr, 3);
    check("se_at20", q_obs.size() > 20 ? q_obs[20].e : 1'bx, 1);
    check("se_at23", q_obs.size() > 23 ? q_obs[23].e : 1'bx, 1);
    check("se_at25", q_obs.size() > 25 ? q_obs[25].e : 1'bx, 1);
    check("se_locked39", q_obs.size() > 39 ? q_obs[39].l : 1'bx, 1);
    check("los_locked3", q_obs.size() > 42 ? q_obs[42].l : 1'bx, 1);
    check("los_unlock4", q_obs.size() > 43 ? q_obs[43].l : 1'bx, 0);
    check("los_state4", q_obs.size() > 43 ? q_obs[43].st : 2'bx, 1);
    check("relock_pre", q_obs.size() > 47 ? q_obs[47].l : 1'bx, 0);
    check("relock_5th", q_obs.size() > 48 ? q_obs[48].l : 1'bx, 1);
    drain("err");
    check("err_count_total", ec, 7);
    check("carrier_loss_state", st, 0);
    check("carrier_loss_locked", lk, 0);
    // clear_err coinciding with a mismatch
    for (int i = 0; i < 6; i++) tx_bit(pn[i], 0);
    tx_anti(1);
    tx_bit(pn[7], 0);
    tx_zero();
    check("clr_sync_err", q_obs.size() > 6 ? q_obs[6].e : 1'bx, 1);
    check("clr_err_zero", q_obs.size() > 6 ? q_obs[6].ec : 8'bx, 0);
    drain("clr");
    // random bit stream with random tone edge counts
    for (int i = 0; i < 24; i++) tx_bit(1'($urandom_range(1, 0)), 1'($urandom_range(9, 0) == 0));
    tx_zero();
    drain("rand");
    check("stray_sync_err", n_stray, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
